// File: rtl/qif_pkg.sv
// Shared types and constants for the QIF neuron/synapse pair.
// Keeping V_TH_DEFAULT here keeps neuron and synapse thresholds aligned.
package qif_pkg;

    typedef logic signed [7:0] data_t;

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        REFRACT  = 2'd1,
        WAIT_LOW = 2'd2
    } syn_state_e;

    localparam data_t I_MAX        = 8'sd127;
    localparam data_t I_MIN        = 8'sh80;
    localparam data_t V_TH_DEFAULT = 8'sd50;

    function automatic data_t sat8(input logic signed [9:0] x);
        if (x > 10'sd127) begin
            return I_MAX;
        end else if (x < -10'sd128) begin
            return I_MIN;
        end else begin
            return x[7:0];
        end
    endfunction

endpackage

// File: rtl/qif_spike_detect.sv
// Spike detector: threshold compare, refractory gate and re-arm on V_mem low.
// det_o is the combinational detect strobe; spike_o is its registered pulse.
module qif_spike_detect
    import qif_pkg::*;
#(
    parameter data_t       V_TH           = V_TH_DEFAULT,
    parameter int unsigned REFRACT_CYCLES = 3
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  data_t v_mem_i,
    output logic  det_o,
    output logic  spike_o
);

    localparam logic [3:0] RC = REFRACT_CYCLES[3:0];

    syn_state_e state_q;
    logic [3:0] cnt_q;
    logic       spike_q;

    assign det_o   = (state_q == ARMED) && (v_mem_i >= V_TH);
    assign spike_o = spike_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ARMED;
            cnt_q   <= 4'd0;
            spike_q <= 1'b0;
        end else begin
            spike_q <= det_o;
            unique case (state_q)
                ARMED: begin
                    if (det_o) begin
                        if (RC == 4'd0) begin
                            state_q <= WAIT_LOW;
                        end else begin
                            state_q <= REFRACT;
                            cnt_q   <= RC;
                        end
                    end
                end
                REFRACT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    if (v_mem_i < V_TH) begin
                        state_q <= ARMED;
                    end
                end
                default: state_q <= ARMED;
            endcase
        end
    end

endmodule

// File: rtl/qif_synapse.sv
// QIF synapse: spike detect plus decaying, saturating synaptic current.
// Optional spike counter port enabled by QIF_SYN_SPIKE_CNT_EN.
module qif_synapse
    import qif_pkg::*;
#(
    parameter data_t       V_TH           = V_TH_DEFAULT,
    parameter int unsigned TAU_SHIFT      = 2,
    parameter int unsigned REFRACT_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic signed [7:0] V_mem,
    input  logic signed [7:0] weight,
    input  logic              syn_en,
    output logic              spike,
`ifdef QIF_SYN_SPIKE_CNT_EN
    output logic [7:0]        spike_cnt,
`endif
    output logic signed [7:0] I_syn
);

    logic              det;
    data_t             i_syn_q, i_syn_d;
    logic signed [9:0] cur, dec, add, sum;

    qif_spike_detect #(
        .V_TH           (V_TH),
        .REFRACT_CYCLES (REFRACT_CYCLES)
    ) u_det (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .v_mem_i (V_mem),
        .det_o   (det),
        .spike_o (spike)
    );

    // Positive residues below 2^TAU_SHIFT would stall; force a unit step.
    always_comb begin
        cur = $signed({{2{i_syn_q[7]}}, i_syn_q});
        dec = cur >>> TAU_SHIFT;
        if (dec == 10'sd0 && cur > 10'sd0) begin
            dec = 10'sd1;
        end
        add = 10'sd0;
        if (det && syn_en) begin
            add = $signed({{2{weight[7]}}, weight});
        end
        sum     = cur - dec + add;
        i_syn_d = sat8(sum);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            i_syn_q <= '0;
        end else begin
            i_syn_q <= i_syn_d;
        end
    end

    assign I_syn = i_syn_q;

`ifdef QIF_SYN_SPIKE_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    assign cnt_d = det ? cnt_q + 8'd1 : cnt_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign spike_cnt = cnt_q;
`else
    // Spike counting compiled out.
`endif

endmodule

// File: tb/tb_qif_synapse.sv
// Self-checking bench for qif_synapse: directed scenarios then random traffic.
// Reference model works on edge indices and integer arithmetic.
module tb_qif_synapse;

    localparam int VTH = 50;
    localparam int TAU = 2;
    localparam int RC  = 3;

    logic              clk    = 1'b0;
    logic              rst_n  = 1'b1;
    logic signed [7:0] V_mem  = '0;
    logic signed [7:0] weight = '0;
    logic              syn_en = 1'b0;
    logic              spike;
    logic signed [7:0] I_syn;
`ifdef QIF_SYN_SPIKE_CNT_EN
    logic [7:0]        spike_cnt;
`endif

    always #5 clk = ~clk;

    qif_synapse #(
        .V_TH           (8'sd50),
        .TAU_SHIFT      (TAU),
        .REFRACT_CYCLES (RC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .V_mem     (V_mem),
        .weight    (weight),
        .syn_en    (syn_en),
        .spike     (spike),
`ifdef QIF_SYN_SPIKE_CNT_EN
        .spike_cnt (spike_cnt),
`endif
        .I_syn     (I_syn)
    );

    int total = 0;
    int bad   = 0;

    int edge_n;
    int last_sp;
    bit seen_low;
    int m_i;
    bit m_sp;
    int m_cnt;

    task automatic check(input string tag,
                         input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        edge_n   = 0;
        last_sp  = -100;
        seen_low = 1'b1;
        m_i      = 0;
        m_sp     = 1'b0;
        m_cnt    = 0;
    endtask

    // A spike needs V>=VTH and a below-threshold edge seen after the
    // refractory window of the previous spike.
    task automatic model_edge();
        int v, w, d, p, nx;
        bit det;
        v = V_mem;
        w = weight;
        edge_n++;
        det = (v >= VTH) && seen_low;
        if (!det && edge_n > last_sp + RC && v < VTH) seen_low = 1'b1;
        if (det) begin
            seen_low = 1'b0;
            last_sp  = edge_n;
            m_cnt    = (m_cnt + 1) % 256;
        end
        p = 1 << TAU;
        if (m_i >= 0) d = m_i / p;
        else          d = -((-m_i + p - 1) / p);
        if (m_i > 0 && d == 0) d = 1;
        nx = m_i - d + ((det && syn_en) ? w : 0);
        if (nx > 127)  nx = 127;
        if (nx < -128) nx = -128;
        m_i  = nx;
        m_sp = det;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("spike", spike, m_sp);
        check("I_syn", I_syn, m_i);
`ifdef QIF_SYN_SPIKE_CNT_EN
        check("spike_cnt", spike_cnt, m_cnt);
`endif
    endtask

    task automatic steps(input int n, input int v);
        for (int i = 0; i < n; i++) begin
            V_mem = 8'(v);
            step();
        end
    endtask

    // Assert reset mid-cycle, check outputs clear without a clock edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b1;
        #1;
        check({tag, "_spike"}, spike, 0);
        check({tag, "_I"}, I_syn, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
    endtask

    initial begin
        int nsp;
        int exp2 [5];
        exp2 = '{40, 30, 23, 18, 14};
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_spike", spike, 0);
        check("rst_I", I_syn, 0);
        rst_n = 1'b0;

        // single spike, decay trajectory
        weight = 8'sd40;
        syn_en = 1'b1;
        steps(1, 10);
        steps(1, 30);
        steps(1, 55);
        check("t2_spike", spike, 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) steps(1, -20);
            check("t2_traj", I_syn, exp2[i]);
        end
        steps(1, -20);
        check("t2_nospike", spike, 0);
        steps(14, -20);

        // async reset with I_syn nonzero
        steps(1, 55);
        check("t1_pre", I_syn, 40);
        V_mem = -8'sd20;
        async_reset("t1");

        // saturation positive
        weight = 8'sd127;
        steps(1, 60);
        check("t3_k", I_syn, 127);
        steps(3, 60);
        steps(1, 10);
        check("t3_k4", I_syn, 41);
        steps(1, 60);
        check("t3_k5_spike", spike, 1);
        check("t3_k5_I", I_syn, 127);
        steps(25, -20);

        // saturation negative
        weight = 8'sh80;
        steps(1, 60);
        check("t3n_k", I_syn, -128);
        steps(3, 60);
        steps(1, 10);
        steps(1, 60);
        check("t3n_k5", I_syn, -128);
        steps(30, -20);

        // hold high -> one spike
        weight = 8'sd5;
        nsp = 0;
        for (int i = 0; i < 20; i++) begin
            steps(1, 60);
            if (spike === 1'b1) nsp++;
        end
        check("t4_once", nsp, 1);
        steps(1, 0);
        steps(1, 60);
        check("t4_again", spike, 1);
        steps(15, -20);

        // negative decay
        weight = -8'sd3;
        steps(1, 60);
        check("t5_m3", I_syn, -3);
        steps(1, -20);
        check("t5_m2", I_syn, -2);
        steps(1, -20);
        check("t5_m1", I_syn, -1);
        steps(1, -20);
        check("t5_0", I_syn, 0);
        steps(3, -20);
        check("t5_hold", I_syn, 0);

        // syn_en=0
        syn_en = 1'b0;
        weight = 8'sd100;
        steps(1, 60);
        check("t5_en_spike", spike, 1);
        check("t5_en_I", I_syn, 0);
        steps(6, -20);

        // reset mid-refractory
        syn_en = 1'b1;
        weight = 8'sd20;
        steps(3, 55);
        V_mem = 8'sd55;
        async_reset("t6");
        steps(1, 55);
        check("t6_spike", spike, 1);
`ifdef QIF_SYN_SPIKE_CNT_EN
        check("t6_cnt", spike_cnt, 1);
`endif
        steps(6, -20);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) V_mem = 8'($urandom);
            else V_mem = 8'($urandom_range(30, 70));
            weight = 8'($urandom);
            syn_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 149) == 0) async_reset("rnd_rst");
            else step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qif_synapse.md
Name: qif_synapse

Overview:
- Downstream consumer of a QIF neuron's membrane voltage and source of the next neuron's I_syn.
- Detects presynaptic spikes on the 8-bit signed V_mem stream.
- Applies a refractory/re-arm gate to the detected spikes.
- Produces an exponentially decaying, saturating 8-bit signed synaptic current by adding a programmable weight on each spike.
- Sits between one neuron's V_mem output and the next neuron's I_syn input.

Parameters:
- V_TH, 50: spike detection threshold, signed 8-bit; must match the presynaptic neuron's threshold.
- TAU_SHIFT, 2: decay shift; each cycle I_syn loses I_syn>>>TAU_SHIFT. Legal range 1..6.
- REFRACT_CYCLES, 3: cycles V_mem is ignored after a spike. Legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-high (asserted = 1, despite the name).
- V_mem  in  8  signed presynaptic membrane voltage.
- weight  in  8  signed synaptic weight, sampled on the spike edge.
- syn_en  in  1  when 0, spikes are still detected but weight is not added.
- spike  out  1  registered one-cycle pulse per detected spike.
- I_syn  out  8  signed synaptic current to the postsynaptic neuron.
- spike_cnt  out  8  only when QIF_SYN_SPIKE_CNT_EN is defined.

Behaviour:
- Reset (async, rst_n=1): state=ARMED, refractory counter=0, spike=0, I_syn=0, spike_cnt=0. Reset overrides every other event, including mid-refractory.
- FSM states: ARMED, REFRACT, WAIT_LOW.
  - ARMED: if V_mem >= V_TH (signed compare) at edge k, then spike=1 after edge k. Next state is REFRACT with counter=REFRACT_CYCLES, or WAIT_LOW if REFRACT_CYCLES=0. Otherwise stay in ARMED.
  - REFRACT: V_mem ignored. The counter decrements each edge; on the edge where the counter is 1, go to WAIT_LOW. REFRACT therefore lasts exactly REFRACT_CYCLES cycles.
  - WAIT_LOW: if V_mem < V_TH, go to ARMED; otherwise stay. A V_mem held at or above threshold therefore yields exactly one spike.
- spike is 1 for exactly one cycle per detection; it is 0 in all other cycles.
- Minimum spike spacing is REFRACT_CYCLES+2 edges.
- Decay term d (computed every edge):
  - d = I_syn >>> TAU_SHIFT (arithmetic shift).
  - If d==0 and I_syn>0, then d=1. This guarantees positive values reach 0.
  - Negative values reach 0 naturally, because -1>>>n = -1.
- Current update every edge: I_syn <= sat8(I_syn - d + add).
  - add = weight when a spike is detected at this edge and syn_en=1; otherwise add = 0.
  - Compute in 10-bit signed, then clamp to [-128, +127].
- Latency: the weight contribution is visible on I_syn in the same cycle spike goes high (one edge after V_mem crosses).
- A weight change during REFRACT or WAIT_LOW has no effect; weight is only sampled on the spike edge.
- I_syn=0 with no spike stays at 0.

Optional Feature:
- Macro: QIF_SYN_SPIKE_CNT_EN.
- Defined: port spike_cnt exists. It increments by 1 on every detected spike (regardless of syn_en), wraps 255 to 0, and is cleared by reset.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package qif_pkg holds:
  - the 8-bit signed data type;
  - I_MAX=127 and I_MIN=-128;
  - the FSM state enum (ARMED, REFRACT, WAIT_LOW);
  - the default V_TH=50, shared with the neuron so that thresholds stay consistent.
- One sub-module is natural: qif_spike_detect. It contains the FSM plus the refractory counter, outputs a spike-detected strobe, and leaves the decay and saturation datapath in qif_synapse.

Test Plan:
1. Reset: rst_n=1 asynchronously mid-cycle with I_syn=40 -> I_syn=0, spike=0 and state ARMED immediately, without waiting for a clock edge.
2. Single spike: weight=40, syn_en=1, V_mem sequence 10,30,55,-20,-20...
   - -> spike pulses exactly one cycle, after the 55 edge.
   - -> I_syn follows 40, 30, 23, 18, 14, ... down to 0.
3. Saturation (REFRACT_CYCLES=3, weight=127):
   - Stimulus: V_mem>=50 at edge k, <50 at k+4, >=50 at k+5.
   - -> I_syn follows 127, 96, 72, 54, 41, then 127 at k+5 (31+127 clamped).
   - -> spike pulses at k and k+5.
   - Repeat with weight=-128 -> clamps at -128.
4. Hold high: V_mem=60 for 20 cycles -> exactly one spike. A second spike occurs only after V_mem drops to 0 and rises back to 60.
5. Negative decay and syn_en:
   - weight=-3 on a spike -> I_syn follows -3, -2, -1, 0 and then holds.
   - With syn_en=0, a spike still pulses but I_syn stays 0.
6. Reset mid-refractory: assert rst_n two cycles after a spike, then release. Keep V_mem=55 throughout, including the first edge after release -> a new spike on that first edge after release (no leftover refractory state); spike_cnt=1 when the macro is enabled.
